// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC result path. The AHB-Lite bridge and the
// result FIFO both size their datapaths from these values.
package cordic_pkg;

  localparam int CORDIC_DATA_W     = 32;
  localparam int CORDIC_FIFO_DEPTH = 8;

endpackage : cordic_pkg

// File: rtl/cordic_fifo_mem.sv
// Register-file storage for the CORDIC result FIFO.
//   HCLK     : write clock
//   wr_en    : write strobe, one word per cycle
//   wr_addr  : write index
//   wr_data  : word to store
//   rd_addr  : read index (asynchronous read)
//   rd_data  : word at rd_addr
// The contents are not reset; the FIFO controller masks stale entries.
module cordic_fifo_mem
  import cordic_pkg::*;
#(
  parameter int  DATA_W = CORDIC_DATA_W,
  parameter int  DEPTH  = CORDIC_FIFO_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              HCLK,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : cordic_fifo_mem

// File: rtl/cordic_result_fifo.sv
// First-word-fall-through FIFO buffering CORDIC results for the AHB-Lite
// bridge. Dropped pushes raise a sticky overflow flag.
//   HCLK                : clock
//   HRESET              : synchronous active-high reset
//   in_data             : CORDIC result word
//   valid_out_interface : push request
//   read_fifo_en        : pop request (ignored while empty)
//   clr_overflow        : clears overflow (a same-cycle overflow wins)
//   out_fifo            : head word, zero while empty
//   empty / full        : occupancy flags from the registered level
//   level               : occupancy, 0..DEPTH
//   overflow            : sticky, a push was dropped
module cordic_result_fifo
  import cordic_pkg::*;
#(
  parameter int  DATA_W = CORDIC_DATA_W,
  parameter int  DEPTH  = CORDIC_FIFO_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [DATA_W-1:0] in_data,
  input  logic              valid_out_interface,
  input  logic              read_fifo_en,
  input  logic              clr_overflow,
  output logic [DATA_W-1:0] out_fifo,
  output logic              empty,
  output logic              full,
  output logic [LVL_W-1:0]  level,
  output logic              overflow
);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              push_acc, pop_acc, push_drop;
  logic [DATA_W-1:0] head_word;

  // Flags come only from the registered level, so nothing here depends
  // combinationally on the request inputs.
  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign pop_acc   = read_fifo_en && !empty;
  assign push_acc  = valid_out_interface && (!full || pop_acc);
  assign push_drop = valid_out_interface && full && !pop_acc;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    // DEPTH is a power of two, so pointer wrap is the natural roll-over.
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_acc && !pop_acc)      level_d = level_q + LVL_W'(1);
    else if (pop_acc && !push_acc) level_d = level_q - LVL_W'(1);
    if (clr_overflow) overflow_d = 1'b0;
    if (push_drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  cordic_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .HCLK    (HCLK),
    .wr_en   (push_acc && !HRESET),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_ptr_q),
    .rd_data (head_word)
  );

  // Unreset storage may hold stale words; hide them while empty.
  assign out_fifo = empty ? '0 : head_word;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule : cordic_result_fifo

// File: tb/tb_cordic_result_fifo.sv
// Directed bench for cordic_result_fifo (DEPTH=8). Stimulus pushes each word
// it expects to be accepted into a scoreboard queue; a negedge monitor pops
// the queue and compares out_fifo whenever a pop is about to be taken.
module tb_cordic_result_fifo;
  import cordic_pkg::*;

  localparam int DW = 32;
  localparam int D  = 8;
  localparam int LW = 4;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          valid_out_interface = 1'b0;
  logic          read_fifo_en = 1'b0;
  logic          clr_overflow = 1'b0;
  logic [DW-1:0] out_fifo;
  logic          empty, full, overflow;
  logic [LW-1:0] level;

  int            n_chk  = 0;
  int            n_pass = 0;
  logic [DW-1:0] sb[$];
  int            mlvl = 0;

  always #5 HCLK = ~HCLK;

  cordic_result_fifo #(.DATA_W(DW), .DEPTH(D)) dut (
    .HCLK                (HCLK),
    .HRESET              (HRESET),
    .in_data             (in_data),
    .valid_out_interface (valid_out_interface),
    .read_fifo_en        (read_fifo_en),
    .clr_overflow        (clr_overflow),
    .out_fifo            (out_fifo),
    .empty               (empty),
    .full                (full),
    .level               (level),
    .overflow            (overflow)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // One clock of stimulus; the acceptance rules below come from the
  // specification and decide what enters the scoreboard.
  task automatic step(input bit push, input logic [DW-1:0] d, input bit pop,
                      input bit clr = 1'b0, input bit rst = 1'b0);
    bit pa, wa;
    HRESET = rst; valid_out_interface = push; in_data = d;
    read_fifo_en = pop; clr_overflow = clr;
    if (rst) begin
      sb.delete();
      mlvl = 0;
    end else begin
      pa = pop && (mlvl > 0);
      wa = push && ((mlvl < D) || pa);
      if (wa) sb.push_back(d);
      mlvl = mlvl + int'(wa) - int'(pa);
    end
    @(posedge HCLK);
    #1;
    HRESET = 1'b0; valid_out_interface = 1'b0; read_fifo_en = 1'b0; clr_overflow = 1'b0;
  endtask

  // Monitor: a pop will be taken at the next edge, so the head must match.
  always @(negedge HCLK) begin
    if (!HRESET && read_fifo_en && !empty) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL pop_data: got 0x%0h with no word expected", out_fifo);
      end else begin
        chk("pop_data", out_fifo, sb.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    step(0, '0, 0, 0, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out", out_fifo, 0);

    // Single word, one-cycle latency, FWFT
    step(1, 32'h0000_1234, 0);
    chk("one_empty", empty, 0);
    chk("one_level", level, 1);
    chk("one_out", out_fifo, 32'h0000_1234);
    step(0, '0, 1);
    chk("one_pop_empty", empty, 1);
    chk("one_pop_out", out_fifo, 0);

    // Fill, overflow drop, drain in order
    for (int i = 0; i < 8; i++) step(1, 32'h10 + i, 0);
    chk("fill_full", full, 1);
    chk("fill_level", level, 8);
    chk("fill_ovf", overflow, 0);
    chk("fill_head", out_fifo, 32'h10);
    step(1, 32'hFF, 0);
    chk("drop_ovf", overflow, 1);
    chk("drop_level", level, 8);
    chk("drop_head", out_fifo, 32'h10);
    for (int i = 0; i < 8; i++) step(0, '0, 1);
    chk("drain_empty", empty, 1);
    chk("drain_level", level, 0);
    chk("sticky_ovf", overflow, 1);
    step(0, '0, 0, 1);
    chk("clr_ovf", overflow, 0);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) step(1, 32'h10 + i, 0);
    step(1, 32'hAA, 1);
    chk("pp_full_level", level, 8);
    chk("pp_full_ovf", overflow, 0);
    chk("pp_full_head", out_fifo, 32'h11);
    for (int i = 0; i < 8; i++) step(0, '0, 1);
    chk("pp_drain_empty", empty, 1);

    // Pop held while empty, then push with pop still high
    for (int i = 0; i < 5; i++) begin
      step(0, '0, 1);
      chk("stall_level", level, 0);
    end
    step(1, 32'h55, 1);
    chk("stall_push_level", level, 1);
    chk("stall_push_out", out_fifo, 32'h55);
    step(0, '0, 1);
    chk("stall_pop_empty", empty, 1);

    // Wrap twice: 1..20 with level peaking at 5
    for (int i = 1; i <= 5; i++) step(1, i, 0);
    chk("wrap_peak", level, 5);
    for (int i = 6; i <= 20; i++) step(1, i, 1);
    chk("wrap_level", level, 5);
    chk("wrap_head", out_fifo, 16);
    for (int i = 0; i < 5; i++) step(0, '0, 1);
    chk("wrap_empty", empty, 1);

    // Reset mid-operation with push and pop in the reset cycle
    for (int i = 0; i < 8; i++) step(1, 32'h30 + i, 0);
    step(1, 32'hFE, 0);
    for (int i = 0; i < 5; i++) step(0, '0, 1);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_ovf", overflow, 1);
    step(1, 32'h99, 1, 0, 1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_out", out_fifo, 0);

    // Clear and new overflow together: set wins
    for (int i = 0; i < 8; i++) step(1, 32'h40 + i, 0);
    step(1, 32'hEE, 0, 1);
    chk("set_wins_ovf", overflow, 1);
    step(0, '0, 0, 1);
    chk("clr_after_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) step(0, '0, 1);
    chk("final_empty", empty, 1);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_cordic_result_fifo

// File: doc/cordic_result_fifo.md
CORDIC_RESULT_FIFO -- requirements
Module: cordic_result_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result word width.
REQ-002 SHALL have parameter DEPTH, default 8, entries; power of two, >= 2.
REQ-003 SHALL have port HCLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port HRESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  DATA_W  CORDIC result word.
REQ-006 SHALL have port valid_out_interface  input  1  CORDIC result-valid strobe; push request.
REQ-007 SHALL have port read_fifo_en  input  1  pop request from the AHB-Lite CORDIC bridge.
REQ-008 SHALL have port clr_overflow  input  1  clears the overflow flag.
REQ-009 SHALL have port out_fifo  output  DATA_W  head word, first-word-fall-through.
REQ-010 SHALL have port empty  output  1  level == 0.
REQ-011 SHALL have port full  output  1  level == DEPTH.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port overflow  output  1  sticky flag; a push was dropped.

Function
REQ-014 Push accepted SHALL equal valid_out_interface && (!full || pop accepted in the same cycle).
REQ-015 Pop accepted SHALL equal read_fifo_en && !empty; read_fifo_en while empty SHALL be ignored with no state change and no error, because the bridge holds it high while stalling.
REQ-016 An accepted push SHALL write in_data at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-017 An accepted pop SHALL increment rd_ptr modulo DEPTH.
REQ-018 level SHALL be +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-019 empty and full SHALL be derived from the registered level only, with no combinational path from the push or pop inputs.
REQ-020 out_fifo SHALL equal mem[rd_ptr] when !empty and all-zero when empty.
REQ-021 Latency SHALL be 1 cycle: a word pushed at edge N appears on out_fifo, with empty=0, after edge N if the FIFO was empty.
REQ-022 A pop at edge N SHALL present the next word, or zero if now empty, after edge N.
REQ-023 Simultaneous push and pop when full SHALL accept both, keep level=DEPTH, and not set overflow.
REQ-024 Simultaneous push and pop when empty SHALL accept the push only, giving level=1.
REQ-025 A push attempted when full without an accepted pop SHALL drop the word, leave memory and pointers unchanged, and set overflow.
REQ-026 overflow SHALL remain set until clr_overflow or HRESET; a new overflow in the same cycle as clr_overflow SHALL leave it set (set wins).
REQ-027 Pointer wrap-around SHALL be seamless; data order SHALL be strict FIFO across the wrap.

Reset
REQ-028 HRESET high at an edge SHALL set wr_ptr=0, rd_ptr=0, level=0, overflow=0, giving empty=1, full=0, and out_fifo=0 after that edge.
REQ-029 Reset during operation SHALL discard all buffered words; push and pop in the reset cycle SHALL be ignored.
REQ-030 Memory contents SHALL NOT require reset; REQ-020 masks stale data.

Structure
REQ-031 A shared package cordic_pkg SHALL hold CORDIC_DATA_W=32 and CORDIC_FIFO_DEPTH=8, both used by this block and the bridge.
REQ-032 Storage SHALL be one sub-module, cordic_fifo_mem: DEPTH x DATA_W register file, one synchronous write port, one asynchronous read port.
REQ-033 Pointer, level, flag and FWFT output logic SHALL reside in cordic_result_fifo.

Verification (DEPTH=8)
REQ-034 Reset, then push 0x0000_1234 at one edge -> next cycle empty=0, level=1, out_fifo=0x0000_1234; one pop -> empty=1, out_fifo=0.
REQ-035 Push 8 words 0x10..0x17 -> full=1, level=8; 9th push 0xFF -> dropped, overflow=1; 8 pops return 0x10..0x17 in order.
REQ-036 Fill to 8, then push 0xAA with pop in the same cycle -> level stays 8, overflow=0, head becomes 0x11, 0xAA is last out.
REQ-037 Hold read_fifo_en=1 for 5 cycles while empty, then push 0x55 -> no level change while empty; 0x55 visible the cycle after push and popped at the next edge.
REQ-038 Push 20 words 1..20 with interleaved pops, level peaking at 5 -> pointers wrap twice; output sequence is exactly 1..20.
REQ-039 With level=3 and overflow=1, assert HRESET one cycle together with push and pop -> level=0, empty=1, overflow=0, out_fifo=0; clr_overflow plus a simultaneous overflow -> overflow stays 1.
